// File: rtl/mac_engine_if.sv
// Bus between the matrix-multiply control/status block and mac_engine:
// operand load, entry stream in, regfile write port and status out.
interface mac_engine_if #(
  parameter int DW = 8,
  parameter int AW = 2*DW+1
);
  logic            start;
  logic [4*DW-1:0] a_flat;
  logic [4*DW-1:0] b_flat;
  logic            multiply;
  logic [3:0]      entry_in;
  logic            wr_en;
  logic [1:0]      wr_addr;
  logic [AW-1:0]   wr_data;
  logic            busy;
  logic            done;
  logic            err;
  logic [1:0]      state_dbg;

  // Entry handshake: entry_in is consumed on every rising clk edge where
  // multiply=1; there is no back-pressure, so the sender owns the pacing.
  modport master (
    output start, a_flat, b_flat, multiply, entry_in,
    input  wr_en, wr_addr, wr_data, busy, done, err, state_dbg
  );
  modport slave (
    input  start, a_flat, b_flat, multiply, entry_in,
    output wr_en, wr_addr, wr_data, busy, done, err, state_dbg
  );
endinterface

// File: rtl/mac_engine.sv
// 2x2 matrix-multiply MAC: decodes entry indices into (i,j,k), multiplies,
// accumulates over k and writes C[i][j]. MAC_SIGNED_EN selects signed operands.
module mac_engine #(
  parameter int DW = 8,
  parameter int AW = 2*DW+1
) (
  input logic        clk,
  input logic        reset,
  mac_engine_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [4*DW-1:0] a_q, b_q;
  logic [2:0]      exp_cnt;
  logic            accept, reject;
  logic            s1_vld;
  logic [AW-1:0]   s1_p;
  logic [2:0]      s1_tag;
  logic [AW-1:0]   acc;
  logic            wr_en_q;
  logic [1:0]      wr_addr_q;
  logic [AW-1:0]   wr_data_q;
  logic            err_q;
  logic [1:0]      a_idx, b_idx;
  logic [DW-1:0]   op_a, op_b;
  logic [AW-1:0]   prod;

  // A[i][k] lives at slot {i,k}, B[k][j] at slot {k,j}.
  always_comb begin
    a_idx = {bus.entry_in[2], bus.entry_in[0]};
    b_idx = {bus.entry_in[0], bus.entry_in[1]};
    op_a  = a_q[int'(a_idx)*DW +: DW];
    op_b  = b_q[int'(b_idx)*DW +: DW];
  end

`ifdef MAC_SIGNED_EN
  logic signed [2*DW-1:0] prod_raw;
  assign prod_raw = $signed(op_a) * $signed(op_b);
  assign prod     = {{(AW-2*DW){prod_raw[2*DW-1]}}, prod_raw};
`else
  logic [2*DW-1:0] prod_raw;
  assign prod_raw = op_a * op_b;
  assign prod     = {{(AW-2*DW){1'b0}}, prod_raw};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_RUN;
      S_RUN: begin
        if (bus.multiply) begin
          if (!bus.entry_in[3] && bus.entry_in[2:0] == exp_cnt) begin
            accept = 1'b1;
            if (exp_cnt == 3'd7) state_nxt = S_DRAIN;
          end else begin
            reject    = 1'b1;
            state_nxt = S_DRAIN;
          end
        end
      end
      // Both the product stage and the write stage must be empty.
      S_DRAIN: if (!s1_vld && !wr_en_q) state_nxt = err_q ? S_IDLE : S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q       <= '0;
      b_q       <= '0;
      exp_cnt   <= '0;
      err_q     <= 1'b0;
      s1_vld    <= 1'b0;
      s1_p      <= '0;
      s1_tag    <= '0;
      acc       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        a_q     <= bus.a_flat;
        b_q     <= bus.b_flat;
        err_q   <= 1'b0;
        exp_cnt <= '0;
      end
      if (reject) err_q <= 1'b1;
      // A pause in the entry stream means the status register restarted at 0.
      if (state == S_RUN) begin
        if (accept)             exp_cnt <= exp_cnt + 3'd1;
        else if (!bus.multiply) exp_cnt <= '0;
      end
      s1_vld <= accept;
      if (accept) begin
        s1_p   <= prod;
        s1_tag <= bus.entry_in[2:0];
      end
      wr_en_q <= 1'b0;
      if (s1_vld) begin
        if (!s1_tag[0]) begin
          acc <= s1_p;
        end else begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= s1_tag[2:1];
          wr_data_q <= acc + s1_p;
        end
      end
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state == S_RUN) || (state == S_DRAIN);
  assign bus.done      = (state == S_DONE) && !err_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_mac_engine.sv
// Bench for mac_engine: directed matrix cases plus randomized entry streams,
// checked by a write scoreboard fed from a dot-product reference model.
module tb_mac_engine;
  localparam int DW = 8;
  localparam int AW = 2*DW+1;

  logic clk;
  logic reset;
  mac_engine_if #(.DW(DW), .AW(AW)) bus ();

  mac_engine #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW+1:0] exp_q[$];
  int            done_cnt = 0;
  int            exp_done = 0;

  // reference model state
  logic [4*DW-1:0] m_a, m_b;
  bit              m_run;
  int              m_cnt;
  bit              m_err;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic int elem(input logic [4*DW-1:0] f, input int idx);
    logic [DW-1:0] v;
    v = f[idx*DW +: DW];
`ifdef MAC_SIGNED_EN
    return int'($signed(v));
`else
    return int'(v);
`endif
  endfunction

  // C[i][j] = sum over k of A[i][k]*B[k][j], reduced to AW bits
  function automatic logic [AW-1:0] cval(input int i, input int j);
    int s;
    s = elem(m_a, 2*i) * elem(m_b, j) + elem(m_a, 2*i+1) * elem(m_b, 2+j);
    return s[AW-1:0];
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset && bus.wr_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: addr %0d data %0h with nothing expected", bus.wr_addr, bus.wr_data);
      end else begin
        logic [AW+1:0] w;
        w = exp_q.pop_front();
        check("write", {30'd0, bus.wr_addr}, {30'd0, w[AW+1:AW]});
        check("write_data", 32'(bus.wr_data), 32'(w[AW-1:0]));
      end
    end
    if (reset && bus.done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b, input bit with_mult);
    bus.start    = 1'b1;
    bus.a_flat   = a;
    bus.b_flat   = b;
    bus.multiply = with_mult;
    bus.entry_in = 4'd0;
    m_a   = a;
    m_b   = b;
    m_run = 1'b1;
    m_cnt = 0;
    m_err = 1'b0;
    tick();
    bus.start    = 1'b0;
    bus.multiply = 1'b0;
  endtask

  task automatic send(input logic [3:0] e, input bit also_start);
    bus.multiply = 1'b1;
    bus.entry_in = e;
    bus.start    = also_start;
    if (also_start) begin
      bus.a_flat = $urandom;
      bus.b_flat = $urandom;
    end
    if (m_run) begin
      if (!e[3] && int'(e) == m_cnt) begin
        if (e[0]) exp_q.push_back({e[2:1], cval(int'(e[2]), int'(e[1]))});
        m_cnt++;
        if (m_cnt == 8) begin
          m_run = 1'b0;
          exp_done++;
        end
      end else begin
        m_err = 1'b1;
        m_run = 1'b0;
      end
    end
    tick();
    bus.multiply = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic gap(input int n);
    bus.multiply = 1'b0;
    repeat (n) tick();
    if (m_run) m_cnt = 0;
  endtask

  task automatic send_all();
    for (int e = 0; e < 8; e++) send(4'(e), 1'b0);
  endtask

  task automatic finish_seq(input string name);
    int k;
    k = 0;
    while (bus.busy && k < 60) begin
      tick();
      k++;
    end
    if (k >= 60) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: busy still %0d after %0d cycles, expected 0", name, bus.busy, k);
    end
    repeat (3) tick();
    check({name, "_done_count"}, 32'(done_cnt), 32'(exp_done));
    check({name, "_err"}, {31'd0, bus.err}, {31'd0, m_err});
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start    = 1'b0;
    bus.a_flat   = '0;
    bus.b_flat   = '0;
    bus.multiply = 1'b0;
    bus.entry_in = '0;
    m_run = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
    m_a   = '0;
    m_b   = '0;
    reset = 1'b0;
    #12;
    check("reset_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("reset_busy",  {31'd0, bus.busy},  32'd0);
    check("reset_done",  {31'd0, bus.done},  32'd0);
    check("reset_err",   {31'd0, bus.err},   32'd0);
    check("reset_wr_data", 32'(bus.wr_data), 32'd0);
    check("reset_state", {30'd0, bus.state_dbg}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // basic product, with multiply also high on the start cycle (start wins)
    do_start(32'h04030201, 32'h08070605, 1'b1);
    check("run_busy", {31'd0, bus.busy}, 32'd1);
    send_all();
    finish_seq("basic");

    // gap restart: first pass writes addr0, then a full pass
    do_start(32'h04030201, 32'h08070605, 1'b0);
    send(4'd0, 1'b0);
    send(4'd1, 1'b0);
    send(4'd2, 1'b0);
    gap(1);
    send_all();
    finish_seq("gap");

    // out-of-order entry
    do_start(32'h04030201, 32'h08070605, 1'b0);
    send(4'd0, 1'b0);
    send(4'd2, 1'b0);
    check("err_after_bad", {31'd0, bus.err}, 32'd1);
    finish_seq("order");

    // entry with bit 3 set is rejected
    do_start(32'h04030201, 32'h08070605, 1'b0);
    send(4'd8, 1'b0);
    finish_seq("bit3");

    // reset mid-run between entries 4 and 5
    do_start(32'h04030201, 32'h08070605, 1'b0);
    for (int e = 0; e < 5; e++) send(4'(e), 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("midreset_busy",  {31'd0, bus.busy},  32'd0);
    check("midreset_done",  {31'd0, bus.done},  32'd0);
    check("midreset_err",   {31'd0, bus.err},   32'd0);
    exp_q.delete();
    m_run = 1'b0;
    m_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    do_start(32'h04030201, 32'h08070605, 1'b0);
    send_all();
    finish_seq("after_reset");

    // all-ones operands
    do_start(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    send_all();
    finish_seq("max");
`ifndef MAC_SIGNED_EN
    check("max_value_model", 32'(cval(1, 1)), 32'h1FC02);
`else
    // A=[[-1,2],[3,-4]], B=identity
    do_start(32'hFC0302FF, 32'h01000001, 1'b0);
    send_all();
    finish_seq("signed");
    check("signed_model_c11", 32'(cval(1, 1)), 32'h1FFFC);
`endif

    // randomized streams with pauses, stray starts and bad entries
    for (int t = 0; t < 10; t++) begin
      int gaps;
      int guard;
      int r;
      gaps  = 0;
      guard = 0;
      do_start($urandom, $urandom, t[0]);
      while (m_run && guard < 200) begin
        guard++;
        r = $urandom_range(0, 19);
        if (r == 0 && gaps < 2) begin
          gaps++;
          gap($urandom_range(1, 3));
        end else if (r == 1 && t >= 7) begin
          send(4'($urandom_range(0, 15)), 1'b0);
        end else begin
          send(4'(m_cnt), r == 2);
        end
      end
      finish_seq("random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end
endmodule
